fetch_unit: RTL and testbench

Program-counter and fetch-sequencing stage of the basic processor. Holds the 10-bit program counter, sequences start/run/halt, and on a taken branch loads the absolute target returned by the branch-target lookup table. It drives the table's 5-bit pointer and consumes the 10-bit target in the same cycle. Its output feeds instruction-memory addressing.

---
 rtl/fetch_unit_if.sv | 29 ++
 rtl/fetch_unit.sv | 101 ++++++++++
 tb/tb_fetch_unit.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: control/branch inputs from decode and ALU, PC/status/count outputs to imem and host.
// master = decode/host side driving controls, slave = fetch_unit.
interface fetch_unit_if #(
  parameter int PC_W   = 10,
  parameter int LUT_AW = 5,
  parameter int CNT_W  = 16
);
  logic              Start;
  logic              Halt;
  logic              BranchEn;
  logic              BranchFlag;
  logic [LUT_AW-1:0] BrIdx;
  logic [LUT_AW-1:0] LutAddr;
  logic [PC_W-1:0]   Target;
  logic [PC_W-1:0]   ProgCtr;
  logic              Running;
  logic              Done;
  logic [CNT_W-1:0]  InstCnt;

  modport master (
    output Start, Halt, BranchEn, BranchFlag, BrIdx, Target,
    input  LutAddr, ProgCtr, Running, Done, InstCnt
  );

  modport slave (
    input  Start, Halt, BranchEn, BranchFlag, BrIdx, Target,
    output LutAddr, ProgCtr, Running, Done, InstCnt
  );
endinterface

// File: rtl/fetch_unit.sv
// Program counter + IDLE/RUN/HALTED sequencing; 1-cycle start/branch/halt latency, no backpressure.
// Optional retired-instruction counter enabled by `define FETCH_INST_CNT_EN (else InstCnt is tied to 0).
module fetch_unit #(
  parameter int              PC_W       = 10,
  parameter int              LUT_AW     = 5,
  parameter logic [PC_W-1:0] START_ADDR = '0,
  parameter int              CNT_W      = 16
) (
  input logic         Clk,
  input logic         Reset,
  fetch_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            running_q, done_q;
  logic            taken;

  assign taken = bus.BranchEn & bus.BranchFlag;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      pc_q      <= START_ADDR;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      running_q <= (state_d == RUN);
      done_q    <= (state_d == HALTED);
    end
  end

  // Halt outranks a taken branch so the PC stays parked on the halt instruction.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      IDLE: begin
        pc_d = START_ADDR;
        if (bus.Start) state_d = RUN;
      end
      RUN: begin
        if (bus.Halt) begin
          state_d = HALTED;
        end else if (taken) begin
          pc_d = bus.Target;
        end else begin
          pc_d = pc_q + 1'b1;
        end
      end
      HALTED: begin
        if (bus.Start) begin
          state_d = RUN;
          pc_d    = START_ADDR;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = START_ADDR;
      end
    endcase
  end

  assign bus.LutAddr = bus.BrIdx;
  assign bus.ProgCtr = pc_q;
  assign bus.Running = running_q;
  assign bus.Done    = done_q;

`ifdef FETCH_INST_CNT_EN
  logic             launch;
  logic             retire;
  logic [CNT_W-1:0] cnt_q;

  assign launch = (state_q != RUN) && bus.Start;
  assign retire = (state_q == RUN) && !bus.Halt;

  // Held through HALTED so the host can read the final count.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
    end else if (launch) begin
      cnt_q <= '0;
    end else if (retire && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.InstCnt = cnt_q;
`else
  assign bus.InstCnt = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit plus hand sequences for async reset and PC wrap.
module tb_fetch_unit;

`ifdef FETCH_INST_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  typedef struct {
    logic        start;
    logic        halt;
    logic        ben;
    logic        bflag;
    logic [4:0]  idx;
    logic [9:0]  tgt;
    logic [9:0]  pc;
    logic        run;
    logic        done;
    logic [15:0] cnt;
  } vec_t;

  logic Clk;
  logic Reset;
  int   n_cmp;
  int   n_bad;
  vec_t vecs[$];

  fetch_unit_if #(.PC_W(10), .LUT_AW(5), .CNT_W(16)) b1 ();
  fetch_unit_if #(.PC_W(10), .LUT_AW(5), .CNT_W(16)) b2 ();

  fetch_unit #(.PC_W(10), .LUT_AW(5), .START_ADDR(10'h000), .CNT_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .bus(b1)
  );

  fetch_unit #(.PC_W(10), .LUT_AW(5), .START_ADDR(10'h3FE), .CNT_W(16)) dut_wrap (
    .Clk(Clk), .Reset(Reset), .bus(b2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", nm, idx, act, exp);
    end
  endtask

  task automatic add(input logic st, input logic h, input logic be, input logic bf,
                     input logic [4:0] ix, input logic [9:0] tg,
                     input logic [9:0] pc, input logic rn, input logic dn, input logic [15:0] cn);
    vec_t v;
    v.start = st; v.halt = h; v.ben = be; v.bflag = bf; v.idx = ix; v.tgt = tg;
    v.pc = pc; v.run = rn; v.done = dn; v.cnt = cn;
    vecs.push_back(v);
  endtask

  function automatic logic [15:0] ecnt(input logic [15:0] c);
    return CNT_ON ? c : 16'd0;
  endfunction

  initial begin
    n_cmp = 0;
    n_bad = 0;
    Reset = 1'b1;
    b1.Start = 0; b1.Halt = 0; b1.BranchEn = 0; b1.BranchFlag = 0; b1.BrIdx = '0; b1.Target = '0;
    b2.Start = 0; b2.Halt = 0; b2.BranchEn = 0; b2.BranchFlag = 0; b2.BrIdx = '0; b2.Target = '0;

    //   st h  be bf idx    tgt      -> pc      run done cnt
    add(0, 0, 0, 0, 5'h00, 10'h000,  10'h000, 0, 0, 0);   // idle, no start
    add(0, 1, 1, 1, 5'h03, 10'h2AA,  10'h000, 0, 0, 0);   // controls ignored in IDLE
    add(1, 0, 0, 0, 5'h00, 10'h000,  10'h000, 1, 0, 0);   // launch
    for (int i = 1; i <= 6; i++)
      add(0, 0, 0, 0, 5'h00, 10'h000, 10'(i), 1, 0, 16'(i));
    add(0, 1, 0, 0, 5'h00, 10'h000,  10'h006, 0, 1, 6);   // halt at PC 6
    add(0, 1, 1, 1, 5'h0A, 10'h155,  10'h006, 0, 1, 6);   // frozen in HALTED
    add(1, 0, 0, 0, 5'h00, 10'h000,  10'h000, 1, 0, 0);   // relaunch
    add(1, 0, 0, 0, 5'h00, 10'h000,  10'h001, 1, 0, 1);   // Start held: ignored
    add(1, 0, 0, 0, 5'h00, 10'h000,  10'h002, 1, 0, 2);
    add(1, 0, 0, 0, 5'h00, 10'h000,  10'h003, 1, 0, 3);
    add(0, 0, 1, 1, 5'h00, 10'h013,  10'h013, 1, 0, 4);   // taken branch at PC 3
    add(0, 0, 1, 1, 5'h1F, 10'h020,  10'h020, 1, 0, 5);
    add(0, 1, 1, 1, 5'h02, 10'h03B,  10'h020, 0, 1, 5);   // halt beats branch
    add(1, 0, 0, 0, 5'h00, 10'h000,  10'h000, 1, 0, 0);
    add(0, 0, 0, 0, 5'h00, 10'h000,  10'h001, 1, 0, 1);
    add(0, 0, 0, 0, 5'h00, 10'h000,  10'h002, 1, 0, 2);
    add(0, 0, 0, 0, 5'h00, 10'h000,  10'h003, 1, 0, 3);
    add(0, 0, 1, 0, 5'h05, 10'h3AA,  10'h004, 1, 0, 4);   // not taken at PC 3
    add(0, 0, 1, 1, 5'h11, 10'h000,  10'h000, 1, 0, 5);   // target 0 is legal
    add(0, 0, 1, 1, 5'h04, 10'h030,  10'h030, 1, 0, 6);
    add(0, 0, 0, 0, 5'h00, 10'h000,  10'h031, 1, 0, 7);
    add(0, 1, 0, 0, 5'h00, 10'h000,  10'h031, 0, 1, 7);   // halt at 0x031
    add(1, 0, 0, 0, 5'h00, 10'h000,  10'h000, 1, 0, 0);   // relaunch from 0x031

    @(posedge Clk);
    @(posedge Clk);
    #1;
    chk("rst_pc",   0, 32'(b1.ProgCtr), 32'h000);
    chk("rst_run",  0, 32'(b1.Running), 32'd0);
    chk("rst_done", 0, 32'(b1.Done),    32'd0);
    chk("rst_cnt",  0, 32'(b1.InstCnt), 32'd0);
    Reset = 1'b0;

    foreach (vecs[i]) begin
      b1.Start      = vecs[i].start;
      b1.Halt       = vecs[i].halt;
      b1.BranchEn   = vecs[i].ben;
      b1.BranchFlag = vecs[i].bflag;
      b1.BrIdx      = vecs[i].idx;
      b1.Target     = vecs[i].tgt;
      #1;
      chk("lut", i, 32'(b1.LutAddr), 32'(vecs[i].idx));
      @(posedge Clk);
      #1;
      chk("pc",   i, 32'(b1.ProgCtr), 32'(vecs[i].pc));
      chk("run",  i, 32'(b1.Running), 32'(vecs[i].run));
      chk("done", i, 32'(b1.Done),    32'(vecs[i].done));
      chk("cnt",  i, 32'(b1.InstCnt), 32'(ecnt(vecs[i].cnt)));
    end

    // Async reset mid-run: five more increments, then Reset between edges.
    b1.Start = 0; b1.Halt = 0; b1.BranchEn = 0; b1.BranchFlag = 0;
    repeat (5) @(posedge Clk);
    #1;
    chk("pre_rst_pc",  0, 32'(b1.ProgCtr), 32'h005);
    chk("pre_rst_cnt", 0, 32'(b1.InstCnt), 32'(ecnt(16'd5)));
    #2;
    Reset = 1'b1;
    #1;
    chk("arst_pc",   0, 32'(b1.ProgCtr), 32'h000);
    chk("arst_run",  0, 32'(b1.Running), 32'd0);
    chk("arst_done", 0, 32'(b1.Done),    32'd0);
    chk("arst_cnt",  0, 32'(b1.InstCnt), 32'd0);
    @(posedge Clk);
    #3;
    Reset = 1'b0;

    // Wrap on the instance launched at 0x3FE.
    @(posedge Clk);
    #1;
    b2.Start = 1'b1;
    @(posedge Clk);
    #1;
    b2.Start = 1'b0;
    chk("wrap_pc",  0, 32'(b2.ProgCtr), 32'h3FE);
    chk("wrap_run", 0, 32'(b2.Running), 32'd1);
    @(posedge Clk);
    #1;
    chk("wrap_pc",  1, 32'(b2.ProgCtr), 32'h3FF);
    @(posedge Clk);
    #1;
    chk("wrap_pc",  2, 32'(b2.ProgCtr), 32'h000);
    chk("wrap_cnt", 2, 32'(b2.InstCnt), 32'(ecnt(16'd2)));
    chk("idle_pc",  0, 32'(b1.ProgCtr), 32'h000);
    chk("idle_run", 0, 32'(b1.Running), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
